// File: rtl/ro_meas_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
// Holds the measurement FSM encoding and the result byte-select helper.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } meas_state_t;

  localparam int GATE_LOG2_DEF   = 10;
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Picks byte 'sel' of a result word; bytes beyond the result width read as zero.
  function automatic logic [7:0] byte_of(input logic [31:0] word,
                                         input logic [1:0]  sel,
                                         input int          nbytes);
    logic [7:0] b;
    b = word[{sel, 3'b000} +: 8];
    if (int'(sel) >= nbytes) b = 8'h00;
    return b;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-flop synchroniser for an asynchronous level, followed by a history flop
// that turns each synchronised rising transition into a one-cycle pulse.
module ro_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              hist_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      hist_reg <= sync_reg[STAGES-1];
    end
  end

  assign rise = sync_reg[STAGES-1] & ~hist_reg;

endmodule

// File: rtl/ro_freq_meter.sv
// Counts rising edges of an asynchronous oscillator over a 2**GATE_LOG2 cycle gate
// and holds the count for byte-wise readout on an 8-bit bus.
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int GATE_LOG2   = GATE_LOG2_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       osc_in,
  input  logic       start,
  input  logic [1:0] byte_sel,
  output logic [7:0] out_byte,
  output logic       busy,
  output logic       valid,
  output logic       overflow
);

  localparam int ARM_W  = $clog2(SYNC_STAGES + 1);
  localparam int NBYTES = CNT_W / 8;

  localparam logic [ARM_W-1:0]     ARM_LAST   = ARM_W'(SYNC_STAGES);
  localparam logic [GATE_LOG2-1:0] TIMER_LAST = '1;
  localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

  logic osc_rise;
  logic start_rise;

  meas_state_t          state_reg, state_next;
  logic [ARM_W-1:0]     arm_reg, arm_next;
  logic [GATE_LOG2-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [CNT_W-1:0]     result_reg, result_next;
  logic                 valid_reg, valid_next;
  logic                 overflow_reg, overflow_next;
  logic [31:0]          result_wide;

  ro_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_osc_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (osc_in),
    .rise (osc_rise)
  );

  // start is a slow host level: one flop plus history is enough.
  ro_edge_sync #(
    .STAGES (1)
  ) u_start_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (start),
    .rise (start_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      arm_reg      <= '0;
      timer_reg    <= '0;
      count_reg    <= '0;
      result_reg   <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      arm_reg      <= arm_next;
      timer_reg    <= timer_next;
      count_reg    <= count_next;
      result_reg   <= result_next;
      valid_reg    <= valid_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    arm_next      = arm_reg;
    timer_next    = timer_reg;
    count_next    = count_reg;
    result_next   = result_reg;
    valid_next    = valid_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start_rise) begin
          state_next    = ARM;
          arm_next      = '0;
          timer_next    = '0;
          count_next    = '0;
          valid_next    = 1'b0;
          overflow_next = 1'b0;
        end
      end

      // Let the synchroniser drain whatever it held before the gate opens.
      ARM: begin
        if (arm_reg == ARM_LAST) begin
          state_next = GATE;
        end else begin
          arm_next = arm_reg + 1'b1;
        end
      end

      GATE: begin
        timer_next = timer_reg + 1'b1;
        if (osc_rise) begin
          if (count_reg == CNT_MAX) begin
            overflow_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
        // The edge on the final gate cycle is folded into the stored result.
        if (timer_reg == TIMER_LAST) begin
          state_next  = DONE;
          result_next = count_next;
          valid_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy        = (state_reg == ARM) || (state_reg == GATE);
  assign valid       = valid_reg;
  assign overflow    = overflow_reg;
  assign result_wide = 32'(result_reg);
  assign out_byte    = byte_of(result_wide, byte_sel, NBYTES);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Drives three meter configurations from one oscillator and start line and checks
// each held result against an edge-list model of the gate window.
module tb_ro_freq_meter;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst;
  logic       osc;
  logic       start;
  logic [1:0] byte_sel;
  logic [7:0] ob [3];
  logic [2:0] busy_v;
  logic [2:0] valid_v;
  logic [2:0] ovf_v;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises [$];

  bit osc_stuck = 1'b1;
  bit osc_level = 1'b0;
  int hp_lo     = 4;
  int hp_hi     = 4;
  int osc_left  = 0;

  int busy_total = 0;
  int busy_base  = 0;

  ro_freq_meter #(.GATE_LOG2(8), .CNT_W(16), .SYNC_STAGES(SYNC)) dut0 (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .byte_sel(byte_sel),
    .out_byte(ob[0]), .busy(busy_v[0]), .valid(valid_v[0]), .overflow(ovf_v[0]));

  ro_freq_meter #(.GATE_LOG2(10), .CNT_W(8), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .byte_sel(byte_sel),
    .out_byte(ob[1]), .busy(busy_v[1]), .valid(valid_v[1]), .overflow(ovf_v[1]));

  ro_freq_meter #(.GATE_LOG2(12), .CNT_W(16), .SYNC_STAGES(SYNC)) dut2 (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .byte_sel(byte_sel),
    .out_byte(ob[2]), .busy(busy_v[2]), .valid(valid_v[2]), .overflow(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator: changes just after a falling edge; every rising edge is logged
  // with the index of the clk rising edge that preceded it.
  always @(negedge clk) begin
    if (osc_stuck) begin
      if (osc_level && !osc) rises.push_back(cyc);
      osc = osc_level;
    end else if (osc_left <= 1) begin
      if (!osc) rises.push_back(cyc);
      osc = ~osc;
      osc_left = int'($urandom_range(hp_hi, hp_lo));
    end else begin
      osc_left--;
    end
  end

  always @(negedge clk) if (busy_v[0] === 1'b1) busy_total++;

  function automatic int g_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 10 : 12;
  endfunction

  function automatic int w_of(input int i);
    return (i == 1) ? 8 : 16;
  endfunction

  // Start seen at posedge s+1, ARM from s+2 for SYNC+1 cycles, gate edges counted
  // at posedges s+SYNC+4 .. s+SYNC+3+2**g, each edge arriving SYNC+1 posedges
  // after the osc rise that caused it.
  function automatic void model(input int s, input int g, input int w,
                                output logic [31:0] res, output logic ovf);
    int lo;
    int hi;
    int n;
    int mx;
    lo = s + SYNC + 4 - (SYNC + 1);
    hi = s + SYNC + 3 + (1 << g) - (SYNC + 1);
    n  = 0;
    foreach (rises[k]) if (rises[k] >= lo && rises[k] <= hi) n++;
    mx  = (1 << w) - 1;
    ovf = (n > mx);
    res = 32'((n > mx) ? mx : n);
  endfunction

  function automatic logic [31:0] exp_byte(input logic [31:0] r, input int w, input int b);
    if (b < w / 8) return (r >> (8 * b)) & 32'hFF;
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(output int s);
    @(negedge clk);
    start     = 1'b1;
    s         = cyc;
    busy_base = busy_total;
    step(2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arm_valid%0d", i), 32'(valid_v[i]), 32'd0);
      check($sformatf("arm_busy%0d", i), 32'(busy_v[i]), 32'd1);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(valid_v[2] === 1'b1 && busy_v[2] === 1'b0) && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("done_in_time", 32'(k < 6000), 32'd1);
  endtask

  task automatic finish_check(input int s, input string name);
    logic [31:0] r [3];
    logic        o [3];
    for (int i = 0; i < 3; i++) model(s, g_of(i), w_of(i), r[i], o[i]);
    for (int b = 0; b < 4; b++) begin
      byte_sel = 2'(b);
      #1;
      for (int i = 0; i < 3; i++)
        check($sformatf("%s_byte%0d_sel%0d", name, i, b), 32'(ob[i]), exp_byte(r[i], w_of(i), b));
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_valid%0d", name, i), 32'(valid_v[i]), 32'd1);
      check($sformatf("%s_busy%0d", name, i), 32'(busy_v[i]), 32'd0);
      check($sformatf("%s_ovf%0d", name, i), 32'(ovf_v[i]), 32'(o[i]));
    end
    check($sformatf("%s_busy_len", name), 32'(busy_total - busy_base), 32'd259);
    $display("meas %-8s start=%0d exp0=%0d exp1=%0d ovf1=%0d exp2=%0d",
             name, s, r[0], r[1], o[1], r[2]);
  endtask

  task automatic meas(input string name);
    int s;
    start = 1'b0;
    step(2);
    launch(s);
    wait_done();
    finish_check(s, name);
  endtask

  task automatic set_square(input int lo, input int hi);
    hp_lo     = lo;
    hp_hi     = hi;
    osc_stuck = 1'b0;
    step(10);
  endtask

  task automatic set_stuck(input bit lvl);
    osc_level = lvl;
    osc_stuck = 1'b1;
    step(10);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst      = 1'b1;
    start    = 1'b0;
    byte_sel = 2'd0;
    step(3);
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst_valid%0d", i), 32'(valid_v[i]), 32'd0);
      check($sformatf("rst_ovf%0d", i), 32'(ovf_v[i]), 32'd0);
    end
    for (int b = 0; b < 2; b++) begin
      byte_sel = 2'(b);
      #1;
      for (int i = 0; i < 3; i++)
        check($sformatf("rst_byte%0d_sel%0d", i, b), 32'(ob[i]), 32'd0);
    end

    set_square(4, 4);
    meas("div8");
    set_stuck(1'b0);
    meas("stuck0");
    set_stuck(1'b1);
    meas("stuck1");
    set_square(2, 2);
    meas("div4");
    set_square(3, 3);
    meas("div6");

    // Asynchronous reset partway through the gate of the shortest window.
    start = 1'b0;
    step(2);
    launch(s);
    step(100);
    byte_sel = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_busy%0d", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("abort_valid%0d", i), 32'(valid_v[i]), 32'd0);
      check($sformatf("abort_ovf%0d", i), 32'(ovf_v[i]), 32'd0);
      check($sformatf("abort_byte%0d", i), 32'(ob[i]), 32'd0);
    end
    $display("abort rst asserted at cycle %0d", cyc);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_square(4, 4);
    meas("post_rst");

    // start held high across more than one window.
    set_square(2, 5);
    start = 1'b0;
    step(2);
    launch(s);
    wait_done();
    finish_check(s, "held");
    step(300);
    finish_check(s, "held2");

    // start toggled while measuring.
    start = 1'b0;
    step(2);
    launch(s);
    step(50);
    start = 1'b0;
    step(2);
    start = 1'b1;
    wait_done();
    finish_check(s, "toggle");

    meas("rearm");

    for (int t = 0; t < 4; t++) begin
      set_square(2, int'($urandom_range(8, 3)));
      step(int'($urandom_range(20, 1)));
      meas($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
